plru_repl_ctrl: RTL and testbench
=================================

Name: plru_repl_ctrl

Overview:
- Per-set tree-PLRU replacement controller for an N-way set-associative cache.
- Stores one (WAYS-1)-bit PLRU tree per set and accepts victim requests from the miss/refill unit.
- Each victim is chosen by priority: invalid-way first, then a lock-aware tree walk. Trees are updated on victim commit and on cache hits.
- Sits between the tag array and the refill FSM.

Parameters:
- WAYS, 8, associativity; power of two, at least 2.
- SETS, 64, number of sets; power of two.
- WAY_BITS, $clog2(WAYS), derived.
- SET_BITS, $clog2(SETS), derived.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- flush_i  in  1  request clear of all PLRU trees
- hit_valid_i  in  1  hit touch strobe
- hit_set_i  in  SET_BITS  set of the hit
- hit_way_i  in  WAY_BITS  way that hit
- req_valid_i  in  1  victim request valid
- req_ready_o  out  1  request accepted when valid&ready
- req_set_i  in  SET_BITS  set needing a victim
- req_way_valid_i  in  WAYS  valid bit per way of the set
- req_lock_i  in  WAYS  1 = way not evictable
- rsp_valid_o  out  1  victim response valid
- rsp_ready_i  in  1  refill FSM commits victim
- rsp_way_oh_o  out  WAYS  victim one-hot
- rsp_way_bin_o  out  WAY_BITS  victim index
- rsp_none_o  out  1  all ways locked; no victim
- busy_o  out  1  not in IDLE

Behaviour:
- Tree layout: heap-indexed, node n has children 2n+1 and 2n+2, node 0 is the root. Bit 0 = go low half, bit 1 = go high half.
- Touch(way): every node on the way's path is set to point away from that way.
- Storage: SETS x (WAYS-1) array, not reset; it is cleared only by the FLUSH sweep.
- FSM states: FLUSH, IDLE, LOOKUP, RESP. Async reset enters FLUSH with sweep counter 0.
  - FLUSH: clear one set per cycle, SETS cycles, then IDLE. req_ready_o=0; hit touches dropped.
  - IDLE: req_ready_o=1. On accept, latch set, valid mask and lock mask, then go to LOOKUP. flush_i in IDLE goes to FLUSH; flush_i has priority over a same-cycle request, which is not accepted.
  - LOOKUP: read tree, compute victim, register outputs, go to RESP.
  - RESP: rsp_valid_o=1, outputs held stable. On rsp_ready_i, go to IDLE.
- Commit: if rsp_none_o=0, the victim's touch is applied to the set. flush_i in LOOKUP/RESP is held pending and taken on return to IDLE.
- Latency: accept at cycle T gives rsp_valid_o at T+2. Back-to-back throughput is one request per 3 cycles minimum.
- Victim selection, in priority order:
  1. If (~valid & ~lock) != 0, pick the lowest-index such way; the tree is not consulted.
  2. Otherwise walk the tree. At each node, follow the bit unless that subtree has no unlocked way, in which case take the sibling.
  3. If lock is all ones, rsp_none_o=1, rsp_way_oh_o=0, rsp_way_bin_o=0, and no tree update on commit.
- Hit touches: applied in any state except FLUSH. A hit in LOOKUP to the latched set is forwarded, so the walk sees the post-hit tree.
- Commit is read-modify-write on the current tree. If a hit to the same set occurs in the commit cycle, apply the hit touch first, then the victim touch.
- Reset values: req_ready_o=0, rsp_valid_o=0, rsp_way_oh_o=0, rsp_way_bin_o=0, rsp_none_o=0, busy_o=1.

Optional Feature:
- Macro PLRU_REPL_PERF_CNT_EN.
- With it: 32-bit saturating counters for accepted requests, invalid-way picks, no-victim responses and applied hit touches, exposed on output port perf_cnt_o [4x32]. Counters clear on reset and on flush.
- Without it: no counters; perf_cnt_o is driven to 0.

Decomposition:
- Package plru_repl_pkg holds:
  - FSM state enum;
  - node-count and path-index constant functions;
  - a touch function mapping (tree, way) to the new tree.
- Sub-module plru_tree_victim: combinational lock-aware walk of one tree, outputs one-hot and binary victim plus a none flag. Instantiated once.

Test Plan (WAYS=8, SETS=64):
- Reset: req_ready_o stays 0 for 64 cycles. Then a request for set 5 with valid=8'hFF, lock=0 gives rsp at T+2 with way 0, oh 8'h01.
- Repeated commits to set 5 with all ways valid and no locks give victim sequence 0,4,2,6,1,5,3,7, then 0.
- valid=8'hF7, lock=0 gives way 3, oh 8'h08. A second request with the same masks also gives 3.
- Fresh tree with lock=8'h0F gives way 4. lock=8'hFF gives rsp_none_o=1, oh 0, tree unchanged; the next request with lock=0 gives way 0.
- After reset, set 2: commit way 0 in the same cycle as hit set 2 way 4; the next victim for set 2 is way 6.
- Mid-sequence, flush_i while in RESP: the response completes, then a 64-cycle FLUSH follows, and the next victim is way 0.

Source files
------------

// File: rtl/plru_repl_pkg.sv
// Shared types and tree helpers for the tree-PLRU replacement controller.
// Helpers work on a tree sized for the largest supported associativity.
package plru_repl_pkg;

  localparam int unsigned MaxWays   = 64;
  localparam int unsigned MaxLevels = 6;

  typedef logic [MaxWays-2:0] tree_t;

  typedef enum logic [1:0] {
    StFlush,
    StIdle,
    StLookup,
    StResp
  } state_e;

  function automatic int unsigned plru_node_count(int unsigned ways);
    return ways - 32'd1;
  endfunction

  // Heap index of the node visited at `level` on the way's root-to-leaf path.
  function automatic int unsigned plru_path_node(int unsigned way, int unsigned level,
                                                 int unsigned way_bits);
    int unsigned node;
    node = 32'd0;
    for (int unsigned l = 0; l < MaxLevels; l++) begin
      if (l < level) begin
        node = 32'd2 * node + 32'd1 + ((way >> (way_bits - 32'd1 - l)) & 32'd1);
      end
    end
    return node;
  endfunction

  // Every node on the way's path is made to point away from that way.
  function automatic tree_t plru_touch(tree_t tree, int unsigned way, int unsigned way_bits);
    tree_t       t;
    int unsigned node;
    logic        b;
    t = tree;
    for (int unsigned l = 0; l < MaxLevels; l++) begin
      if (l < way_bits) begin
        node = plru_path_node(way, l, way_bits);
        b    = ((way >> (way_bits - 32'd1 - l)) & 32'd1) != 32'd0;
        for (int unsigned n = 0; n < MaxWays - 1; n++) begin
          if (n == node) t[n] = ~b;
        end
      end
    end
    return t;
  endfunction

endpackage

// File: rtl/plru_tree_victim.sv
// Combinational lock-aware walk of one PLRU tree.
// A node's pointer is overridden when its target subtree holds no unlocked way.
module plru_tree_victim #(
  parameter int unsigned Ways = 8,
  localparam int unsigned WayBits = $clog2(Ways)
) (
  input  logic [Ways-2:0]    tree_i,
  input  logic [Ways-1:0]    lock_i,
  output logic [Ways-1:0]    way_oh_o,
  output logic [WayBits-1:0] way_bin_o,
  output logic               none_o
);

  logic [WayBits-1:0] bin;

  always_comb begin : walk
    int   node;
    int   base;
    int   half;
    logic low_free;
    logic high_free;
    logic dir;
    node = 0;
    base = 0;
    bin  = '0;
    for (int l = 0; l < int'(WayBits); l++) begin
      half      = int'(Ways) >> (l + 1);
      low_free  = 1'b0;
      high_free = 1'b0;
      for (int i = 0; i < int'(Ways); i++) begin
        if (i >= base && i < base + half)            low_free  = low_free  | ~lock_i[i];
        if (i >= base + half && i < base + 2 * half) high_free = high_free | ~lock_i[i];
      end
      dir = 1'b0;
      for (int n = 0; n < int'(Ways) - 1; n++) begin
        if (n == node) dir = tree_i[n];
      end
      if (dir && !high_free)      dir = 1'b0;
      else if (!dir && !low_free) dir = 1'b1;
      bin[WayBits-1-l] = dir;
      base = dir ? base + half : base;
      node = 2 * node + 1 + (dir ? 1 : 0);
    end
  end

  assign none_o    = &lock_i;
  assign way_bin_o = none_o ? '0 : bin;
  assign way_oh_o  = none_o ? '0 : (Ways'(1) << bin);

endmodule

// File: rtl/plru_repl_ctrl.sv
// Per-set tree-PLRU victim selection with invalid-first priority and lock awareness.
// Define PLRU_REPL_PERF_CNT_EN to enable the saturating performance counters.
import plru_repl_pkg::*;

module plru_repl_ctrl #(
  parameter int unsigned WAYS = 8,
  parameter int unsigned SETS = 64,
  localparam int unsigned WAY_BITS = $clog2(WAYS),
  localparam int unsigned SET_BITS = $clog2(SETS)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  input  logic                hit_valid_i,
  input  logic [SET_BITS-1:0] hit_set_i,
  input  logic [WAY_BITS-1:0] hit_way_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [SET_BITS-1:0] req_set_i,
  input  logic [WAYS-1:0]     req_way_valid_i,
  input  logic [WAYS-1:0]     req_lock_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [WAYS-1:0]     rsp_way_oh_o,
  output logic [WAY_BITS-1:0] rsp_way_bin_o,
  output logic                rsp_none_o,
  output logic                busy_o,
  output logic [3:0][31:0]    perf_cnt_o
);

  localparam int unsigned Nodes = plru_node_count(WAYS);

  function automatic logic [Nodes-1:0] touch(input logic [Nodes-1:0]    t,
                                             input logic [WAY_BITS-1:0] w);
    tree_t full;
    full            = '0;
    full[Nodes-1:0] = t;
    full            = plru_touch(full, 32'(w), WAY_BITS);
    return full[Nodes-1:0];
  endfunction

  state_e              state_q, state_d;
  logic [SET_BITS-1:0] sweep_q, sweep_d;
  logic                flush_pend_q, flush_pend_d;
  logic [SET_BITS-1:0] set_q;
  logic [WAYS-1:0]     valid_q, lock_q;
  logic [WAYS-1:0]     rsp_oh_q;
  logic [WAY_BITS-1:0] rsp_bin_q;
  logic                rsp_none_q;

  // Not reset; only the flush sweep clears it.
  logic [Nodes-1:0]    tree_mem [SETS];

  logic                req_accept, hit_en, hit_same, commit;
  logic [Nodes-1:0]    tree_fwd, commit_tree;
  logic [WAYS-1:0]     free, inv_oh, walk_oh;
  logic [WAY_BITS-1:0] inv_bin, walk_bin;
  logic                walk_none, lookup;

  assign req_accept = req_valid_i & req_ready_o;
  assign hit_en     = hit_valid_i & (state_q != StFlush);
  assign hit_same   = hit_en & (hit_set_i == set_q);
  assign commit     = (state_q == StResp) & rsp_ready_i & ~rsp_none_q;
  assign lookup     = (state_q == StLookup);

  // Same-set hit is folded in first so both the walk and the commit see the post-hit tree.
  assign tree_fwd    = hit_same ? touch(tree_mem[set_q], hit_way_i) : tree_mem[set_q];
  assign commit_tree = touch(tree_fwd, rsp_bin_q);

  assign free = ~valid_q & ~lock_q;

  always_comb begin
    inv_bin = '0;
    for (int i = int'(WAYS) - 1; i >= 0; i--) begin
      if (free[i]) inv_bin = WAY_BITS'(i);
    end
  end
  assign inv_oh = WAYS'(1) << inv_bin;

  plru_tree_victim #(
    .Ways (WAYS)
  ) u_victim (
    .tree_i    (tree_fwd),
    .lock_i    (lock_q),
    .way_oh_o  (walk_oh),
    .way_bin_o (walk_bin),
    .none_o    (walk_none)
  );

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StFlush;
      sweep_q      <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sweep_q      <= sweep_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d      = state_q;
    sweep_d      = '0;
    flush_pend_d = flush_pend_q;
    unique case (state_q)
      StFlush: begin
        sweep_d = sweep_q + 1'b1;
        if (sweep_q == SET_BITS'(SETS - 1)) state_d = StIdle;
      end
      StIdle: begin
        if (flush_i || flush_pend_q) begin
          state_d      = StFlush;
          flush_pend_d = 1'b0;
        end else if (req_valid_i) begin
          state_d = StLookup;
        end
      end
      StLookup: begin
        if (flush_i) flush_pend_d = 1'b1;
        state_d = StResp;
      end
      StResp: begin
        if (flush_i) flush_pend_d = 1'b1;
        if (rsp_ready_i) state_d = StIdle;
      end
      default: state_d = StFlush;
    endcase
  end

  // FSM outputs
  always_comb begin
    req_ready_o = (state_q == StIdle) & ~flush_i & ~flush_pend_q;
    rsp_valid_o = (state_q == StResp);
    busy_o      = (state_q != StIdle);
  end

  assign rsp_way_oh_o  = rsp_oh_q;
  assign rsp_way_bin_o = rsp_bin_q;
  assign rsp_none_o    = rsp_none_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      set_q      <= '0;
      valid_q    <= '0;
      lock_q     <= '0;
      rsp_oh_q   <= '0;
      rsp_bin_q  <= '0;
      rsp_none_q <= 1'b0;
    end else begin
      if (req_accept) begin
        set_q   <= req_set_i;
        valid_q <= req_way_valid_i;
        lock_q  <= req_lock_i;
      end
      if (lookup) begin
        if (|free) begin
          rsp_oh_q   <= inv_oh;
          rsp_bin_q  <= inv_bin;
          rsp_none_q <= 1'b0;
        end else begin
          rsp_oh_q   <= walk_oh;
          rsp_bin_q  <= walk_bin;
          rsp_none_q <= walk_none;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (state_q == StFlush) begin
      tree_mem[sweep_q] <= '0;
    end else begin
      if (commit) tree_mem[set_q] <= commit_tree;
      if (hit_en && !(commit && hit_same)) begin
        tree_mem[hit_set_i] <= touch(tree_mem[hit_set_i], hit_way_i);
      end
    end
  end

`ifdef PLRU_REPL_PERF_CNT_EN
  logic [3:0][31:0] perf_q;
  logic [3:0]       perf_inc;

  assign perf_inc[0] = req_accept;
  assign perf_inc[1] = lookup & (|free);
  assign perf_inc[2] = lookup & ~(|free) & walk_none;
  assign perf_inc[3] = hit_en;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_q <= '0;
    end else if (state_q == StFlush) begin
      perf_q <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (perf_inc[i] && perf_q[i] != '1) perf_q[i] <= perf_q[i] + 32'd1;
      end
    end
  end

  assign perf_cnt_o = perf_q;
`else
  assign perf_cnt_o = '0;
`endif

endmodule

// File: tb/tb_plru_repl_ctrl.sv
// Table-driven bench for plru_repl_ctrl with a response scoreboard.
module tb_plru_repl_ctrl;

  localparam int MPlain     = 0;
  localparam int MHitLookup = 1;
  localparam int MHitCommit = 2;
  localparam int MFlushResp = 3;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic             flush_i = 1'b0;
  logic             hit_valid_i = 1'b0;
  logic [5:0]       hit_set_i = '0;
  logic [2:0]       hit_way_i = '0;
  logic             req_valid_i = 1'b0;
  logic             req_ready_o;
  logic [5:0]       req_set_i = '0;
  logic [7:0]       req_way_valid_i = '0;
  logic [7:0]       req_lock_i = '0;
  logic             rsp_valid_o;
  logic             rsp_ready_i = 1'b0;
  logic [7:0]       rsp_way_oh_o;
  logic [2:0]       rsp_way_bin_o;
  logic             rsp_none_o;
  logic             busy_o;
  logic [3:0][31:0] perf_cnt_o;

  always #5 clk_i = ~clk_i;

  plru_repl_ctrl #(
    .WAYS (8),
    .SETS (64)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .flush_i         (flush_i),
    .hit_valid_i     (hit_valid_i),
    .hit_set_i       (hit_set_i),
    .hit_way_i       (hit_way_i),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .req_set_i       (req_set_i),
    .req_way_valid_i (req_way_valid_i),
    .req_lock_i      (req_lock_i),
    .rsp_valid_o     (rsp_valid_o),
    .rsp_ready_i     (rsp_ready_i),
    .rsp_way_oh_o    (rsp_way_oh_o),
    .rsp_way_bin_o   (rsp_way_bin_o),
    .rsp_none_o      (rsp_none_o),
    .busy_o          (busy_o),
    .perf_cnt_o      (perf_cnt_o)
  );

  typedef struct {
    logic [5:0] set;
    logic [7:0] valid;
    logic [7:0] lock;
    logic [2:0] bin;
    logic [7:0] oh;
    logic       none;
    int         mode;
    logic [2:0] hway;
  } vec_t;

  typedef struct packed {
    logic [2:0] bin;
    logic [7:0] oh;
    logic       none;
  } exp_t;

  vec_t tbl[19];
  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [5:0] set, input logic [7:0] valid,
                              input logic [7:0] lock, input logic [2:0] bin,
                              input logic [7:0] oh, input logic none, input int mode,
                              input logic [2:0] hway);
    vec_t v;
    v.set = set; v.valid = valid; v.lock = lock; v.bin = bin;
    v.oh = oh; v.none = none; v.mode = mode; v.hway = hway;
    return v;
  endfunction

  task automatic run_req(input vec_t v);
    int   n;
    exp_t e;
    n = 0;
    req_set_i       = v.set;
    req_way_valid_i = v.valid;
    req_lock_i      = v.lock;
    req_valid_i     = 1'b1;
    while (!req_ready_o && n < 300) begin
      @(posedge clk_i); #1;
      n++;
    end
    check("req_ready", 32'(req_ready_o), 32'd1);
    if (!req_ready_o) begin
      req_valid_i = 1'b0;
      return;
    end
    sb.push_back('{bin: v.bin, oh: v.oh, none: v.none});
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    check("lookup_no_rsp", 32'(rsp_valid_o), 32'd0);
    if (v.mode == MHitLookup) begin
      hit_valid_i = 1'b1; hit_set_i = v.set; hit_way_i = v.hway;
    end
    @(posedge clk_i); #1;
    hit_valid_i = 1'b0;
    check("rsp_valid_t2", 32'(rsp_valid_o), 32'd1);
    if (rsp_valid_o) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("rsp_bin", 32'(rsp_way_bin_o), 32'(e.bin));
        check("rsp_oh", 32'(rsp_way_oh_o), 32'(e.oh));
        check("rsp_none", 32'(rsp_none_o), 32'(e.none));
      end
    end
    if (v.mode == MFlushResp) begin
      flush_i = 1'b1;
      @(posedge clk_i); #1;
      flush_i = 1'b0;
      check("resp_hold_valid", 32'(rsp_valid_o), 32'd1);
      check("resp_hold_bin", 32'(rsp_way_bin_o), 32'(v.bin));
    end
    rsp_ready_i = 1'b1;
    if (v.mode == MHitCommit) begin
      hit_valid_i = 1'b1; hit_set_i = v.set; hit_way_i = v.hway;
    end
    @(posedge clk_i); #1;
    rsp_ready_i = 1'b0;
    hit_valid_i = 1'b0;
    check("rsp_drop", 32'(rsp_valid_o), 32'd0);
    if (v.mode == MFlushResp) begin
      // Hits during the sweep must be dropped.
      n = 0;
      while (!req_ready_o && n < 300) begin
        hit_valid_i = (n >= 1 && n < 10);
        hit_set_i   = v.set;
        hit_way_i   = 3'd0;
        @(posedge clk_i); #1;
        n++;
      end
      hit_valid_i = 1'b0;
      check("flush_len", 32'(n), 32'd65);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    tbl[0]  = mk(6'd5,  8'hFF, 8'h00, 3'd0, 8'h01, 1'b0, MPlain,     3'd0);
    tbl[1]  = mk(6'd5,  8'hFF, 8'h00, 3'd4, 8'h10, 1'b0, MPlain,     3'd0);
    tbl[2]  = mk(6'd5,  8'hFF, 8'h00, 3'd2, 8'h04, 1'b0, MPlain,     3'd0);
    tbl[3]  = mk(6'd5,  8'hFF, 8'h00, 3'd6, 8'h40, 1'b0, MPlain,     3'd0);
    tbl[4]  = mk(6'd5,  8'hFF, 8'h00, 3'd1, 8'h02, 1'b0, MPlain,     3'd0);
    tbl[5]  = mk(6'd5,  8'hFF, 8'h00, 3'd5, 8'h20, 1'b0, MPlain,     3'd0);
    tbl[6]  = mk(6'd5,  8'hFF, 8'h00, 3'd3, 8'h08, 1'b0, MPlain,     3'd0);
    tbl[7]  = mk(6'd5,  8'hFF, 8'h00, 3'd7, 8'h80, 1'b0, MPlain,     3'd0);
    tbl[8]  = mk(6'd5,  8'hFF, 8'h00, 3'd0, 8'h01, 1'b0, MPlain,     3'd0);
    tbl[9]  = mk(6'd10, 8'hF7, 8'h00, 3'd3, 8'h08, 1'b0, MPlain,     3'd0);
    tbl[10] = mk(6'd10, 8'hF7, 8'h00, 3'd3, 8'h08, 1'b0, MPlain,     3'd0);
    tbl[11] = mk(6'd20, 8'hFF, 8'h0F, 3'd4, 8'h10, 1'b0, MPlain,     3'd0);
    tbl[12] = mk(6'd21, 8'hFF, 8'hFF, 3'd0, 8'h00, 1'b1, MPlain,     3'd0);
    tbl[13] = mk(6'd21, 8'hFF, 8'h00, 3'd0, 8'h01, 1'b0, MPlain,     3'd0);
    tbl[14] = mk(6'd2,  8'hFF, 8'h00, 3'd0, 8'h01, 1'b0, MHitCommit, 3'd4);
    tbl[15] = mk(6'd2,  8'hFF, 8'h00, 3'd6, 8'h40, 1'b0, MPlain,     3'd0);
    tbl[16] = mk(6'd30, 8'hFF, 8'h00, 3'd4, 8'h10, 1'b0, MHitLookup, 3'd0);
    tbl[17] = mk(6'd5,  8'hFF, 8'h00, 3'd4, 8'h10, 1'b0, MFlushResp, 3'd0);
    tbl[18] = mk(6'd5,  8'hFF, 8'h00, 3'd0, 8'h01, 1'b0, MPlain,     3'd0);

    repeat (3) @(posedge clk_i);
    #1;
    check("rst_ready", 32'(req_ready_o), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("rst_oh", 32'(rsp_way_oh_o), 32'd0);
    check("rst_bin", 32'(rsp_way_bin_o), 32'd0);
    check("rst_none", 32'(rsp_none_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd1);
    rst_ni = 1'b1;

    n = 0;
    while (!req_ready_o && n < 300) begin
      @(posedge clk_i); #1;
      n++;
    end
    check("init_flush_len", 32'(n), 32'd64);
    check("idle_not_busy", 32'(busy_o), 32'd0);

    for (int i = 0; i < 19; i++) begin
      run_req(tbl[i]);
    end

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
